// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: h/v counters plus four frame-synchronous
// pattern modes, with colour, sync and coordinates all leaving one register stage.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int NUM_BARS   = 3,
    parameter int COLOR_W    = 4,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_en,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_color,
    output logic [COLOR_W-1:0]     vgaRed,
    output logic [COLOR_W-1:0]     vgaGreen,
    output logic [COLOR_W-1:0]     vgaBlue,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   video_on,
    output logic                   frame_start,
    output logic [9:0]             pix_x,
    output logic [9:0]             pix_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / NUM_BARS;
    localparam int STEP_W  = H_ACTIVE >> COLOR_W;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_C   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BAR_LAST  = 10'(BAR_W - 1);
    localparam logic [9:0] NB_LAST   = 10'(NUM_BARS - 1);
    localparam logic [9:0] STEP_LAST = 10'(STEP_W - 1);

    logic [9:0]               h, v;
    logic [9:0]               bar_idx, bar_cnt, step_cnt;
    logic [2:0]               bar_col;
    logic [COLOR_W-1:0]       step_idx;
    logic [1:0]               mode_sh;
    logic [3*COLOR_W-1:0]     solid_sh;

    logic                     h_last, v_last, visible, hs_n, vs_n;
    logic [2:0]               bar_rgb;
    logic [COLOR_W-1:0]       r_nxt, g_nxt, b_nxt;

    assign h_last  = (h == H_LAST);
    assign v_last  = (v == V_LAST);
    assign visible = (h < H_ACT_C) && (v < V_ACT_C);
    assign hs_n    = !((h >= HS_START) && (h < HS_END));
    assign vs_n    = !((v >= VS_START) && (v < VS_END));

    // Colour order red, green, blue, yellow, cyan, magenta, white as {R,G,B} enables
    always_comb begin
        bar_rgb = 3'b111;
        case (bar_col)
            3'd0:    bar_rgb = 3'b100;
            3'd1:    bar_rgb = 3'b010;
            3'd2:    bar_rgb = 3'b001;
            3'd3:    bar_rgb = 3'b110;
            3'd4:    bar_rgb = 3'b011;
            3'd5:    bar_rgb = 3'b101;
            default: bar_rgb = 3'b111;
        endcase
    end

    always_comb begin
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (visible) begin
            case (mode_sh)
                2'd0: begin
                    r_nxt = {COLOR_W{bar_rgb[2]}};
                    g_nxt = {COLOR_W{bar_rgb[1]}};
                    b_nxt = {COLOR_W{bar_rgb[0]}};
                end
                2'd1: begin
                    r_nxt = {COLOR_W{h[CHECK_LOG2] ^ v[CHECK_LOG2]}};
                    g_nxt = {COLOR_W{h[CHECK_LOG2] ^ v[CHECK_LOG2]}};
                    b_nxt = {COLOR_W{h[CHECK_LOG2] ^ v[CHECK_LOG2]}};
                end
                2'd2: {r_nxt, g_nxt, b_nxt} = solid_sh;
                default: begin
                    r_nxt = step_idx;
                    g_nxt = step_idx;
                    b_nxt = step_idx;
                end
            endcase
        end
    end

    // Counters; the bar and step indices saturate so the last bar/step absorbs the remainder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h        <= '0;
            v        <= '0;
            bar_idx  <= '0;
            bar_cnt  <= '0;
            bar_col  <= '0;
            step_idx <= '0;
            step_cnt <= '0;
            mode_sh  <= '0;
            solid_sh <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h        <= '0;
                v        <= v_last ? 10'd0 : v + 10'd1;
                bar_idx  <= '0;
                bar_cnt  <= '0;
                bar_col  <= '0;
                step_idx <= '0;
                step_cnt <= '0;
                if (v_last) begin
                    mode_sh  <= mode;
                    solid_sh <= solid_color;
                end
            end else begin
                h <= h + 10'd1;
                if (bar_cnt == BAR_LAST && bar_idx != NB_LAST) begin
                    bar_idx <= bar_idx + 10'd1;
                    bar_cnt <= '0;
                    bar_col <= (bar_col == 3'd6) ? 3'd0 : bar_col + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + 10'd1;
                end
                if (step_cnt == STEP_LAST && step_idx != {COLOR_W{1'b1}}) begin
                    step_idx <= step_idx + 1'b1;
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vgaRed      <= '0;
            vgaGreen    <= '0;
            vgaBlue     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else if (pix_en) begin
            vgaRed      <= r_nxt;
            vgaGreen    <= g_nxt;
            vgaBlue     <= b_nxt;
            hsync       <= hs_n;
            vsync       <= vs_n;
            video_on    <= visible;
            frame_start <= (h == 10'd0) && (v == 10'd0);
            pix_x       <= h;
            pix_y       <= v;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a shrunken timing: a positional pixel model driven
// by enabled-tick count, two instances (3 bars and 9 bars) sharing all inputs.
module tb_vga_pattern_gen;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 24, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int CW = 4, CL = 3;

    logic        clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_color = 12'h000;

    logic [3:0]  r0, g0, b0, r1, g1, b1;
    logic        hs0, vs0, vo0, fs0, hs1, vs1, vo1, fs1;
    logic [9:0]  x0, y0, x1, y1;

    int compared = 0, mismatched = 0;

    int          mh, mv, m_mode;
    logic [11:0] m_solid;
    logic [11:0] e_rgb0, e_rgb1;
    logic [3:0]  e_flags;
    int          e_x, e_y;
    int          en_ticks, last_fs;

    always #5 clk = ~clk;

    vga_pattern_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                      .NUM_BARS(3), .COLOR_W(CW), .CHECK_LOG2(CL)) dut0 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .mode(mode), .solid_color(solid_color),
        .vgaRed(r0), .vgaGreen(g0), .vgaBlue(b0), .hsync(hs0), .vsync(vs0),
        .video_on(vo0), .frame_start(fs0), .pix_x(x0), .pix_y(y0));

    vga_pattern_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                      .NUM_BARS(9), .COLOR_W(CW), .CHECK_LOG2(CL)) dut1 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .mode(mode), .solid_color(solid_color),
        .vgaRed(r1), .vgaGreen(g1), .vgaBlue(b1), .hsync(hs1), .vsync(vs1),
        .video_on(vo1), .frame_start(fs1), .pix_x(x1), .pix_y(y1));

    function automatic logic [11:0] ref_rgb(input int x, input int y, input int md,
                                            input logic [11:0] sol, input int nb);
        int k, s;
        logic [2:0] c;
        if (x >= HA || y >= VA) return 12'h000;
        case (md)
            0: begin
                k = x / (HA / nb);
                if (k > nb - 1) k = nb - 1;
                case (k % 7)
                    0: c = 3'b100;
                    1: c = 3'b010;
                    2: c = 3'b001;
                    3: c = 3'b110;
                    4: c = 3'b011;
                    5: c = 3'b101;
                    default: c = 3'b111;
                endcase
                return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
            end
            1: return ((((x >> CL) ^ (y >> CL)) & 1) == 1) ? 12'hFFF : 12'h000;
            2: return sol;
            default: begin
                s = x / (HA >> CW);
                if (s > 15) s = 15;
                return {s[3:0], s[3:0], s[3:0]};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h (x=%0d y=%0d)", tag, obs, exp, e_x, e_y);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; m_mode = 0; m_solid = 12'h000;
        e_rgb0 = 12'h000; e_rgb1 = 12'h000; e_flags = 4'b1100; e_x = 0; e_y = 0;
        last_fs = -1;
    endtask

    task automatic check_all();
        chk("rgb_bars3", {r0, g0, b0}, e_rgb0);
        chk("rgb_bars9", {r1, g1, b1}, e_rgb1);
        chk("flags0", {hs0, vs0, vo0, fs0}, e_flags);
        chk("flags1", {hs1, vs1, vo1, fs1}, e_flags);
        chk("pix_x", x0, e_x);
        chk("pix_y", y0, e_y);
    endtask

    task automatic tick(input bit en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (en) begin
            en_ticks++;
            e_rgb0  = ref_rgb(mh, mv, m_mode, m_solid, 3);
            e_rgb1  = ref_rgb(mh, mv, m_mode, m_solid, 9);
            e_flags = {!(mh >= HA + HF && mh < HA + HF + HS),
                       !(mv >= VA + VF && mv < VA + VF + VS),
                       (mh < HA && mv < VA), (mh == 0 && mv == 0)};
            e_x = mh;
            e_y = mv;
            if (mh == HT - 1 && mv == VT - 1) begin
                m_mode  = int'(mode);
                m_solid = solid_color;
            end
            mh = (mh + 1) % HT;
            if (mh == 0) mv = (mv + 1) % VT;
        end else begin
            e_flags[0] = 1'b0;
        end
        check_all();
        if (!rst && en && fs0 === 1'b1) begin
            if (last_fs >= 0) chk("frame_period", en_ticks - last_fs, HT * VT);
            last_fs = en_ticks;
        end
    endtask

    initial begin
        int budget;
        en_ticks = 0;
        model_reset();

        // Reset held across edges
        repeat (3) tick(1);
        #2 rst = 1'b0;

        // Continuous run over a full frame and beyond, bars
        repeat (HT * VT + 200) tick(1);

        // Mid-frame switch to solid: current frame keeps bars
        mode = 2'd2;
        solid_color = 12'h5A3;
        repeat (HT * VT + 100) tick(1);

        // Randomised mode/colour changes with gappy pix_en
        repeat (15000) begin
            if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) solid_color = 12'($urandom);
            tick($urandom_range(0, 2) != 0);
        end

        // Mode change landing exactly on the last pixel of a frame
        mode = 2'd0;
        budget = 3 * HT * VT;
        while (!(mh == HT - 1 && mv == VT - 1) && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("reach_last_pixel", (budget > 0), 1);
        mode = 2'd2;
        solid_color = 12'h7C1;
        tick(1);
        tick(1);
        chk("switch_at_00_rgb", {r0, g0, b0}, 12'h7C1);
        chk("switch_at_00_fs", fs0, 1'b1);
        repeat (300) tick(1);

        // Asynchronous reset mid-frame
        mode = 2'd0;
        budget = 3 * HT * VT;
        while (!(mh == 30 && mv == 20) && budget > 0) begin
            tick($urandom_range(0, 3) != 0);
            budget--;
        end
        chk("reach_30_20", (budget > 0), 1);
        tick(1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        tick(1);
        #2 rst = 1'b0;
        tick(1);
        chk("post_reset_x", x0, 10'd0);
        chk("post_reset_fs", fs0, 1'b1);
        chk("post_reset_red", r0, 4'hF);
        repeat (500) tick($urandom_range(0, 1) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
